// File: rtl/quasar_gate_pkg.sv
// Shared types and fixed-point helpers for the single-qubit gate datapath.
// Contents: gate opcode and sequencer state enums, complex amplitude struct,
// fixed-point format constants, INV_SQRT2 and a saturation helper.
// Optional feature macro: GATE_SEQ_HADAMARD_EN (makes op 4 = H legal).
package quasar_gate_pkg;

  // Fixed-point amplitude format shared by the whole state-vector datapath.
  localparam int unsigned FIXED_WIDTH = 16;
  localparam int unsigned FIXED_FRAC  = 14;
  // Wide enough for any intermediate before saturation (products included).
  localparam int unsigned SAT_W       = 2 * FIXED_WIDTH + 2;

`ifdef GATE_SEQ_HADAMARD_EN
  localparam bit HADAMARD_EN = 1'b1;
`else
  localparam bit HADAMARD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    OP_I = 3'd0,
    OP_X = 3'd1,
    OP_Z = 3'd2,
    OP_S = 3'd3,
    OP_H = 3'd4
  } gate_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_APPLY,
    ST_WR0,
    ST_WR1,
    ST_FIN
  } seq_state_t;

  typedef struct packed {
    logic signed [FIXED_WIDTH-1:0] re;
    logic signed [FIXED_WIDTH-1:0] im;
  } amp_t;

  // round(sqrt(n)); used at elaboration to derive INV_SQRT2.
  function automatic int unsigned round_sqrt(input longint unsigned n);
    longint unsigned r;
    longint unsigned t;
    r = 0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'(1) << b);
      if (t * t <= n) r = t;
    end
    if (n > r * r + r) r = r + 64'(1);
    return 32'(r);
  endfunction

  // round(2^FRAC / sqrt(2)) == round(sqrt(2^(2*FRAC-1)))
  localparam logic signed [FIXED_WIDTH-1:0] INV_SQRT2 =
    FIXED_WIDTH'(round_sqrt(64'(1) << (2 * FIXED_FRAC - 1)));

  localparam logic signed [SAT_W-1:0] SAT_MAX =
    SAT_W'((64'(1) << (FIXED_WIDTH - 1)) - 64'(1));
  localparam logic signed [SAT_W-1:0] SAT_MIN = -SAT_MAX - SAT_W'(1);

  // Clamp a wide signed intermediate into the amplitude range.
  function automatic logic signed [FIXED_WIDTH-1:0] sat_fixed(
    input logic signed [SAT_W-1:0] x
  );
    if (x > SAT_MAX) return FIXED_WIDTH'(SAT_MAX);
    if (x < SAT_MIN) return FIXED_WIDTH'(SAT_MIN);
    return FIXED_WIDTH'(x);
  endfunction

endpackage

// File: rtl/gate_pair_apply.sv
// Combinational transform of one amplitude pair (a = |0>, b = |1>).
// Ports: op (gate), a/b (input pair), a_new_c/b_new_c (transformed pair).
// Macro GATE_SEQ_HADAMARD_EN builds the H path (one multiplier pair per lane).
module gate_pair_apply
  import quasar_gate_pkg::*;
(
  input  gate_op_t op,
  input  amp_t     a,
  input  amp_t     b,
  output amp_t     a_new_c,
  output amp_t     b_new_c
);

  // Saturating negation: -MIN clamps to MAX.
  function automatic logic signed [FIXED_WIDTH-1:0] neg_sat(
    input logic signed [FIXED_WIDTH-1:0] x
  );
    return sat_fixed(-SAT_W'(x));
  endfunction

`ifdef GATE_SEQ_HADAMARD_EN
  localparam int unsigned SW = FIXED_WIDTH + 1;
  localparam int unsigned PW = SW + FIXED_WIDTH;
  localparam logic signed [PW-1:0] HALF = PW'(64'(1) << (FIXED_FRAC - 1));

  // (s * INV_SQRT2), rounded half-up, rescaled and saturated.
  function automatic logic signed [FIXED_WIDTH-1:0] scale(
    input logic signed [SW-1:0] s
  );
    logic signed [PW-1:0] p;
    p = PW'(s) * PW'(INV_SQRT2);
    p = p + HALF;
    return sat_fixed(SAT_W'(p >>> FIXED_FRAC));
  endfunction

  logic signed [SW-1:0] sum_re, dif_re, sum_im, dif_im;
  amp_t                 h_a, h_b;

  // Sums carried one bit wider so a+b / a-b never wrap.
  always_comb begin
    sum_re = SW'(a.re) + SW'(b.re);
    dif_re = SW'(a.re) - SW'(b.re);
    sum_im = SW'(a.im) + SW'(b.im);
    dif_im = SW'(a.im) - SW'(b.im);
    h_a    = '{re: scale(sum_re), im: scale(sum_im)};
    h_b    = '{re: scale(dif_re), im: scale(dif_im)};
  end
`endif

  always_comb begin
    a_new_c = a;
    b_new_c = b;
    case (op)
      OP_X: begin
        a_new_c = b;
        b_new_c = a;
      end
      OP_Z: b_new_c = '{re: neg_sat(b.re), im: neg_sat(b.im)};
      OP_S: b_new_c = '{re: neg_sat(b.im), im: b.re};
`ifdef GATE_SEQ_HADAMARD_EN
      OP_H: begin
        a_new_c = h_a;
        b_new_c = h_b;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/gate_sequencer.sv
// Sequences one single-qubit gate over a 2^NUM_QUBITS amplitude state vector
// held in an external single-port RAM (read data returns one cycle later).
// Ports: clk/rst (sync, active-high); instr_valid/instr_ready/instr_op/
// instr_target (instruction handshake); mem_addr/mem_rd_en/mem_rdata_*/
// mem_wr_en/mem_wdata_* (RAM); busy/done/err (status).
// Macro GATE_SEQ_HADAMARD_EN makes op 4 (H) legal; otherwise it is illegal.
module gate_sequencer
  import quasar_gate_pkg::*;
#(
  parameter int unsigned NUM_QUBITS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                instr_valid,
  output logic                                instr_ready,
  input  logic [2:0]                          instr_op,
  input  logic [$clog2(NUM_QUBITS):0]         instr_target,
  output logic [NUM_QUBITS-1:0]               mem_addr,
  output logic                                mem_rd_en,
  input  logic signed [FIXED_WIDTH-1:0]       mem_rdata_real,
  input  logic signed [FIXED_WIDTH-1:0]       mem_rdata_imag,
  output logic                                mem_wr_en,
  output logic signed [FIXED_WIDTH-1:0]       mem_wdata_real,
  output logic signed [FIXED_WIDTH-1:0]       mem_wdata_imag,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int unsigned AW = NUM_QUBITS;
  localparam int unsigned TW = $clog2(NUM_QUBITS) + 1;
  localparam int unsigned KW = AW - 1;

  seq_state_t    state_q, state_d;
  gate_op_t      op_q, op_d;
  logic [TW-1:0] tgt_q, tgt_d;
  logic [KW-1:0] k_q, k_d;
  amp_t          a_q, a_d;
  amp_t          b_q, b_d;
  amp_t          rd_c, a_new_c, b_new_c;
  logic          op_legal_c, tgt_legal_c;
  logic          err_d;
  logic [AW-1:0] bit_c, lo_mask_c, kx_c, i0_c, i1_c;
  logic [AW-1:0] addr_d;
  logic          ready_d, busy_d, done_d, rd_d, wr_d;
  amp_t          wdata_d;

  assign rd_c = {mem_rdata_real, mem_rdata_imag};

  gate_pair_apply u_apply (
    .op      (op_q),
    .a       (a_q),
    .b       (rd_c),
    .a_new_c (a_new_c),
    .b_new_c (b_new_c)
  );

  // Instruction legality.
  always_comb begin
    tgt_legal_c = instr_target < TW'(NUM_QUBITS);
    case (instr_op)
      3'd0, 3'd1, 3'd2, 3'd3: op_legal_c = 1'b1;
      3'd4:                   op_legal_c = HADAMARD_EN;
      default:                op_legal_c = 1'b0;
    endcase
  end

  // Next-state and datapath captures.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tgt_d   = tgt_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          k_d   = '0;
          tgt_d = instr_target;
          if (!(op_legal_c && tgt_legal_c)) begin
            op_d    = OP_I;
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else if (instr_op == 3'(OP_I)) begin
            op_d    = OP_I;
            state_d = ST_FIN;
          end else begin
            op_d    = gate_op_t'(instr_op);
            state_d = ST_RD0;
          end
        end
      end
      ST_RD0:   state_d = ST_RD1;
      ST_RD1: begin
        a_d     = rd_c;
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        b_d     = b_new_c;
        state_d = ST_WR0;
      end
      ST_WR0:   state_d = ST_WR1;
      ST_WR1: begin
        if (k_q == {KW{1'b1}}) begin
          state_d = ST_FIN;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ST_RD0;
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pair addresses for the upcoming cycle: insert a 0 (i0) or 1 (i1) at target.
  always_comb begin
    kx_c      = AW'(k_d);
    bit_c     = AW'(1) << tgt_d;
    lo_mask_c = bit_c - AW'(1);
    i0_c      = ((kx_c & ~lo_mask_c) << 1) | (kx_c & lo_mask_c);
    i1_c      = i0_c | bit_c;
  end

  // Registered outputs decoded from the next state.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FIN);
    rd_d    = (state_d == ST_RD0) || (state_d == ST_RD1);
    wr_d    = (state_d == ST_WR0) || (state_d == ST_WR1);
    addr_d  = mem_addr;
    wdata_d = {mem_wdata_real, mem_wdata_imag};
    case (state_d)
      ST_RD0: addr_d = i0_c;
      ST_RD1: addr_d = i1_c;
      ST_WR0: begin
        addr_d  = i0_c;
        wdata_d = a_new_c;
      end
      ST_WR1: begin
        addr_d  = i1_c;
        wdata_d = b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_I;
      tgt_q          <= '0;
      k_q            <= '0;
      a_q            <= '0;
      b_q            <= '0;
      instr_ready    <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mem_rd_en      <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata_real <= '0;
      mem_wdata_imag <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      tgt_q          <= tgt_d;
      k_q            <= k_d;
      a_q            <= a_d;
      b_q            <= b_d;
      instr_ready    <= ready_d;
      busy           <= busy_d;
      done           <= done_d;
      err            <= err_d;
      mem_rd_en      <= rd_d;
      mem_wr_en      <= wr_d;
      mem_addr       <= addr_d;
      mem_wdata_real <= wdata_d.re;
      mem_wdata_imag <= wdata_d.im;
    end
  end

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer (NUM_QUBITS=3, 16-bit Q2.14 amplitudes).
// A behavioural single-port RAM with one-cycle read latency is serviced from
// the stimulus thread; a vector table covers the single-instruction cases and
// hand-written sequences cover reset mid-operation and reset vs. accept.
module tb_gate_sequencer;

  localparam int unsigned NQ = 3;

  typedef struct packed {
    logic [2:0]       op;
    logic [2:0]       tgt;
    logic [7:0][15:0] init_re;
    logic [7:0][15:0] init_im;
    logic [7:0][15:0] exp_re;
    logic [7:0][15:0] exp_im;
    logic             exp_err;
    logic [7:0]       exp_cyc;
    logic [7:0]       exp_strobes;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               instr_valid;
  logic               instr_ready;
  logic [2:0]         instr_op;
  logic [2:0]         instr_target;
  logic [2:0]         mem_addr;
  logic               mem_rd_en;
  logic signed [15:0] mem_rdata_real;
  logic signed [15:0] mem_rdata_imag;
  logic               mem_wr_en;
  logic signed [15:0] mem_wdata_real;
  logic signed [15:0] mem_wdata_imag;
  logic               busy;
  logic               done;
  logic               err;

  logic signed [15:0] mem_re [8];
  logic signed [15:0] mem_im [8];
  logic               pend_rd, pend_wr;
  logic [2:0]         pend_addr;
  logic signed [15:0] pend_wre, pend_wim;
  int                 rd_cnt, wr_cnt, both_cnt;
  int                 checks, failures;
  vec_t               vecs [7];

  always #5 clk = ~clk;

  gate_sequencer #(.NUM_QUBITS(NQ)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_op       (instr_op),
    .instr_target   (instr_target),
    .mem_addr       (mem_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_rdata_real (mem_rdata_real),
    .mem_rdata_imag (mem_rdata_imag),
    .mem_wr_en      (mem_wr_en),
    .mem_wdata_real (mem_wdata_real),
    .mem_wdata_imag (mem_wdata_imag),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: commit the previous cycle's RAM strobes, then sample outputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (pend_wr) begin
      mem_re[pend_addr] = pend_wre;
      mem_im[pend_addr] = pend_wim;
    end
    if (pend_rd) begin
      mem_rdata_real = mem_re[pend_addr];
      mem_rdata_imag = mem_im[pend_addr];
    end
    pend_rd   = mem_rd_en;
    pend_wr   = mem_wr_en;
    pend_addr = mem_addr;
    pend_wre  = mem_wdata_real;
    pend_wim  = mem_wdata_imag;
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) wr_cnt++;
    if (mem_rd_en && mem_wr_en) both_cnt++;
  endtask

  // Issue one instruction and run to done (bounded); cycle 1 = after accept.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] tgt,
                           output int cyc, output logic err_seen,
                           output logic busy_seen);
    instr_valid  = 1'b1;
    instr_op     = op;
    instr_target = tgt;
    rd_cnt = 0;
    wr_cnt = 0;
    step();
    instr_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      step();
      cyc++;
    end
    err_seen  = err;
    busy_seen = busy;
  endtask

  initial begin
    int   cyc;
    logic e, b;
    int   exp_z [8] = '{1, 0, -3, -2, 5, 4, -6, -7};
    int   exp_r [8] = '{1, 0, 3, 2, 5, 4, 6, 7};

    checks = 0; failures = 0;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    pend_rd = 1'b0; pend_wr = 1'b0; pend_addr = '0; pend_wre = '0; pend_wim = '0;
    mem_rdata_real = '0; mem_rdata_imag = '0;

    for (int v = 0; v < 7; v++) vecs[v] = '0;
    for (int i = 0; i < 8; i++) begin
      // X on qubit 0: neighbours swap.
      vecs[0].init_re[i] = 16'(i);
      vecs[0].exp_re[i]  = 16'(i ^ 1);
      // S on qubit 2: upper half b -> (-b.im, b.re).
      vecs[1].init_re[i] = 16'(10 * i);
      vecs[1].init_im[i] = 16'(-i);
      vecs[1].exp_re[i]  = (i < 4) ? 16'(10 * i) : 16'(i);
      vecs[1].exp_im[i]  = (i < 4) ? 16'(-i) : 16'(10 * i);
      // Z on qubit 0: odd indices negated.
      vecs[2].init_re[i] = 16'(i);
      vecs[2].init_im[i] = 16'(-i);
      vecs[2].exp_re[i]  = (i % 2 == 1) ? 16'(-i) : 16'(i);
      vecs[2].exp_im[i]  = (i % 2 == 1) ? 16'(i) : 16'(-i);
      // I, illegal target, illegal op: state untouched.
      for (int v = 3; v < 6; v++) begin
        vecs[v].init_re[i] = 16'(i + 3);
        vecs[v].init_im[i] = 16'(i);
        vecs[v].exp_re[i]  = 16'(i + 3);
        vecs[v].exp_im[i]  = 16'(i);
      end
    end
    vecs[1].init_re[5] = 16'(100);  vecs[1].init_im[5] = 16'(-200);
    vecs[1].exp_re[5]  = 16'(200);  vecs[1].exp_im[5]  = 16'(100);
    vecs[2].init_re[1] = 16'(-32768); vecs[2].init_im[1] = 16'(0);
    vecs[2].exp_re[1]  = 16'(32767);  vecs[2].exp_im[1]  = 16'(0);
    vecs[0].op = 3'd1; vecs[0].tgt = 3'd0; vecs[0].exp_cyc = 8'd21; vecs[0].exp_strobes = 8'd8;
    vecs[1].op = 3'd3; vecs[1].tgt = 3'd2; vecs[1].exp_cyc = 8'd21; vecs[1].exp_strobes = 8'd8;
    vecs[2].op = 3'd2; vecs[2].tgt = 3'd0; vecs[2].exp_cyc = 8'd21; vecs[2].exp_strobes = 8'd8;
    vecs[3].op = 3'd0; vecs[3].tgt = 3'd1; vecs[3].exp_cyc = 8'd1;
    vecs[4].op = 3'd1; vecs[4].tgt = 3'd3; vecs[4].exp_cyc = 8'd1; vecs[4].exp_err = 1'b1;
    vecs[5].op = 3'd6; vecs[5].tgt = 3'd0; vecs[5].exp_cyc = 8'd1; vecs[5].exp_err = 1'b1;
    // H on qubit 0 of |0>: both amplitudes become 1/sqrt(2) = 11585.
    vecs[6].op = 3'd4; vecs[6].tgt = 3'd0;
    vecs[6].init_re[0] = 16'(16384);
    vecs[6].exp_re[0]  = 16'(16384);
`ifdef GATE_SEQ_HADAMARD_EN
    vecs[6].exp_re[0] = 16'(11585);
    vecs[6].exp_re[1] = 16'(11585);
    vecs[6].exp_cyc = 8'd21; vecs[6].exp_strobes = 8'd8;
`else
    vecs[6].exp_cyc = 8'd1; vecs[6].exp_err = 1'b1;
`endif

    // Reset values.
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_target = '0;
    step(); step();
    chk("reset_ctrl", int'({instr_ready, busy, done, err, mem_rd_en, mem_wr_en}), int'(6'b100000));
    chk("reset_addr", int'(mem_addr), 0);
    chk("reset_wdata", int'({mem_wdata_real, mem_wdata_imag}), 0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 8; i++) begin
        mem_re[i] = $signed(vecs[v].init_re[i]);
        mem_im[i] = $signed(vecs[v].init_im[i]);
      end
      run_instr(vecs[v].op, vecs[v].tgt, cyc, e, b);
      chk($sformatf("v%0d done_cycle", v), cyc, int'(vecs[v].exp_cyc));
      chk($sformatf("v%0d err", v), int'(e), int'(vecs[v].exp_err));
      chk($sformatf("v%0d busy_at_done", v), int'(b), 1);
      chk($sformatf("v%0d rd_count", v), rd_cnt, int'(vecs[v].exp_strobes));
      chk($sformatf("v%0d wr_count", v), wr_cnt, int'(vecs[v].exp_strobes));
      step();
      chk($sformatf("v%0d ready_after", v), int'({instr_ready, busy, done, err}), int'(4'b1000));
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("v%0d re[%0d]", v, i), int'(mem_re[i]), int'($signed(vecs[v].exp_re[i])));
        chk($sformatf("v%0d im[%0d]", v, i), int'(mem_im[i]), int'($signed(vecs[v].exp_im[i])));
      end
    end

    // Reset in the cycle after the third WR1 (cycle 16 = RD0 of pair 3).
    for (int i = 0; i < 8; i++) begin
      mem_re[i] = 16'(i);
      mem_im[i] = '0;
    end
    instr_valid = 1'b1; instr_op = 3'd1; instr_target = 3'd0;
    rd_cnt = 0; wr_cnt = 0;
    step();
    instr_valid = 1'b0;
    cyc = 1;
    while (cyc < 16) begin
      step();
      cyc++;
    end
    chk("rst_mid pre_rd", int'({mem_rd_en, mem_wr_en}), int'(2'b10));
    chk("rst_mid pre_addr", int'(mem_addr), 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid ctrl", int'({instr_ready, busy, done, err, mem_rd_en, mem_wr_en}), int'(6'b100000));
    chk("rst_mid addr", int'(mem_addr), 0);
    chk("rst_mid wdata", int'({mem_wdata_real, mem_wdata_imag}), 0);
    chk("rst_mid writes", wr_cnt, 6);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_mid re[%0d]", i), int'(mem_re[i]), exp_r[i]);

    // Follow-up Z on qubit 1 completes normally.
    run_instr(3'd2, 3'd1, cyc, e, b);
    chk("post_rst done_cycle", cyc, 21);
    chk("post_rst err", int'(e), 0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("post_rst re[%0d]", i), int'(mem_re[i]), exp_z[i]);
      chk($sformatf("post_rst im[%0d]", i), int'(mem_im[i]), 0);
    end

    // Reset coincident with instr_valid: not accepted.
    rst = 1'b1; instr_valid = 1'b1; instr_op = 3'd1; instr_target = 3'd0;
    rd_cnt = 0;
    step();
    rst = 1'b0; instr_valid = 1'b0;
    chk("rst_vs_valid ctrl", int'({instr_ready, busy}), int'(2'b10));
    step(); step();
    chk("rst_vs_valid idle", int'({instr_ready, busy, done}), int'(3'b100));
    chk("rst_vs_valid reads", rd_cnt, 0);

    chk("rd_wr_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
